interrupt_control_unit: RTL and testbench
=========================================

INTERRUPT_CONTROL_UNIT -- requirements
Module: interrupt_control_unit

Interface
REQ-001 SHALL have parameter NUM_IRQ, default 8, number of peripheral IRQ lines (1..16).
REQ-002 SHALL have parameter BASE_ADDR, default 32'h4000, base address of the register block.
REQ-003 SHALL have port clk  input  1  the single clock; all state is updated on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port irq_lines  input  NUM_IRQ  peripheral requests, active-low level (the EIC's eic_irq connects to one bit).
REQ-006 SHALL have port cpu_irq  output  1  active-high interrupt request to the CPU.
REQ-007 SHALL have port cpu_irq_cause  output  4  index of the requested or in-service IRQ.
REQ-008 SHALL have port cpu_irq_ack  input  1  one-cycle pulse: CPU has entered the handler.
REQ-009 SHALL have port cpu_irq_done  input  1  one-cycle pulse: CPU has returned from the handler.
REQ-010 SHALL have ports data_bus_write in 16, data_bus_read out 16, data_bus_addr in 32, data_bus_mode in 2 (00 none, 01 read, 10 write), data_bus_select in 1, forming the data bus slave.

Function
REQ-011 SHALL implement registers: MASK at BASE+0x0 (RW, 1 = enabled), PENDING at BASE+0x4 (write-1-to-clear), ACTIVE at BASE+0x8 (read-only, one-hot), CTRL at BASE+0xC (bit0 global enable RW; bits[2:1] FSM state, read-only).
REQ-012 SHALL perform a bus write only when data_bus_mode==2'b10 and data_bus_select==1 and the address matches exactly; other addresses are ignored.
REQ-013 SHALL drive data_bus_read combinationally from data_bus_addr, returning 16'h0 for unmapped addresses; register bits above NUM_IRQ read 0.
REQ-014 SHALL set PENDING[i] on every rising edge at which irq_lines[i]==0, regardless of MASK (masked requests are remembered).
REQ-015 SHALL give a hardware set priority over a bus W1C or acknowledge clear of the same bit in the same cycle.
REQ-016 SHALL implement FSM states IDLE(00), REQUEST(01), ACTIVE(10).
REQ-017 In IDLE, when CTRL.enable==1 and (PENDING & MASK)!=0, SHALL latch cause = lowest set index of (PENDING & MASK) and enter REQUEST on the next edge.
REQ-018 In REQUEST, SHALL hold cpu_irq=1 and keep the latched cause stable; later changes to MASK, enable or PENDING do not withdraw or change the request.
REQ-019 In REQUEST, on cpu_irq_ack==1, SHALL enter ACTIVE, clear PENDING[cause] (subject to REQ-015) and set ACTIVE to the one-hot of cause.
REQ-020 In ACTIVE, SHALL hold cpu_irq=0, accumulate new pending bits, and on cpu_irq_done==1 clear ACTIVE and return to IDLE; no nesting.
REQ-021 SHALL ignore cpu_irq_ack outside REQUEST and cpu_irq_done outside ACTIVE.
REQ-022 SHALL drive cpu_irq from the registered FSM state only (1 exactly when state==REQUEST); cpu_irq_cause shows the latched cause in REQUEST/ACTIVE and 0 in IDLE.
REQ-023 Latency: irq_lines[i] low before edge N -> PENDING[i]=1 after edge N -> cpu_irq=1 after edge N+1 (when enabled and unmasked).
REQ-024 Return-to-IDLE with eligible pending bits SHALL issue the next request one cycle after entering IDLE.

Reset
REQ-025 On reset low, SHALL asynchronously clear MASK, PENDING, ACTIVE, CTRL.enable, the cause register and the FSM to IDLE; cpu_irq=0 and cpu_irq_cause=0 while reset is low.
REQ-026 Reset asserted during REQUEST or ACTIVE SHALL abandon the interrupt without a further cpu_irq pulse.

Structure
REQ-027 SHALL place the FSM state encoding, register offsets and NUM_IRQ maximum in shared package icu_pkg.
REQ-028 SHALL use one sub-module, irq_priority_encoder (lowest index wins, outputs index and valid flag).

Verification
REQ-029 MASK=0x0004, enable=1, irq_lines[2] low 1 cycle -> PENDING=0x0004 next cycle, cpu_irq=1 with cause=2 the cycle after.
REQ-030 MASK=0x00FF, lines 5 and 3 low simultaneously -> cause=3; after ack/done, cause=5 issued one cycle after IDLE.
REQ-031 MASK=0x0000, line 1 pulsed -> PENDING=0x0002, no cpu_irq; write MASK=0x0002 -> cpu_irq asserts with cause=1.
REQ-032 Line 4 held low across the ack cycle -> PENDING[4] stays 1 (set wins), ACTIVE=0x0010; W1C write 0x0010 after line rises -> PENDING=0.
REQ-033 Reset asserted in ACTIVE -> all registers 0, state IDLE, cpu_irq=0 immediately; stray cpu_irq_done afterwards has no effect.

Source files
------------

// File: rtl/interrupt_control_unit_pkg.sv
// icu_pkg: shared FSM encoding, register offsets and limits for the interrupt control unit
package icu_pkg;
  localparam int NUM_IRQ_MAX = 16;
  localparam logic [31:0] OFF_MASK = 32'h0;
  localparam logic [31:0] OFF_PENDING = 32'h4;
  localparam logic [31:0] OFF_ACTIVE = 32'h8;
  localparam logic [31:0] OFF_CTRL = 32'hC;
  localparam logic [1:0] MODE_WRITE = 2'b10;
  typedef enum logic [1:0] {IDLE = 2'b00, REQUEST = 2'b01, ACTIVE = 2'b10} icu_state_e;
endpackage

// File: rtl/interrupt_control_unit_if.sv
// interrupt_control_unit_if: data bus between a bus master and the interrupt controller registers
interface interrupt_control_unit_if;
  logic [15:0] data_bus_write;
  logic [15:0] data_bus_read;
  logic [31:0] data_bus_addr;
  logic [1:0] data_bus_mode;
  logic data_bus_select;
  modport master(output data_bus_write, data_bus_addr, data_bus_mode, data_bus_select, input data_bus_read);
  modport slave(input data_bus_write, data_bus_addr, data_bus_mode, data_bus_select, output data_bus_read);
endinterface

// File: rtl/interrupt_control_unit_irq_priority_encoder.sv
// irq_priority_encoder: index of the lowest set request bit plus a valid flag
module irq_priority_encoder #(
  parameter int N = 16
) (
  input logic [N-1:0] req,
  output logic [3:0] idx,
  output logic valid
);
  // scan from the top so the lowest set index is the last one written
  always_comb begin
    idx = '0;
    for (int i = N - 1; i >= 0; i--) if (req[i]) idx = 4'(i);
  end
  assign valid = |req;
endmodule

// File: rtl/interrupt_control_unit.sv
// interrupt_control_unit: maskable, non-nesting interrupt controller with a memory-mapped register block
module interrupt_control_unit
  import icu_pkg::*;
#(
  parameter int NUM_IRQ = 8,
  parameter logic [31:0] BASE_ADDR = 32'h4000
) (
  input logic clk,
  input logic reset,
  input logic [NUM_IRQ-1:0] irq_lines,
  output logic cpu_irq,
  output logic [3:0] cpu_irq_cause,
  input logic cpu_irq_ack,
  input logic cpu_irq_done,
  interrupt_control_unit_if.slave bus
);
  localparam logic [15:0] VALID = 16'((32'd1 << NUM_IRQ) - 32'd1);
  logic [15:0] mask, pending, active, eligible, hw_set, w1c, ack_clr, cause_hot;
  logic [3:0] cause, idx;
  logic enable, valid, wr, wr_mask, wr_pending, wr_ctrl;
  icu_state_e state;
  assign wr = bus.data_bus_mode == MODE_WRITE && bus.data_bus_select;
  assign wr_mask = wr && bus.data_bus_addr == BASE_ADDR + OFF_MASK;
  assign wr_pending = wr && bus.data_bus_addr == BASE_ADDR + OFF_PENDING;
  assign wr_ctrl = wr && bus.data_bus_addr == BASE_ADDR + OFF_CTRL;
  assign hw_set = ~16'(irq_lines) & VALID;
  assign cause_hot = 16'd1 << cause;
  assign w1c = wr_pending ? bus.data_bus_write : '0;
  assign ack_clr = state == REQUEST && cpu_irq_ack ? cause_hot : '0;
  assign eligible = pending & mask;
  assign cpu_irq = state == REQUEST;
  assign cpu_irq_cause = state == IDLE ? 4'd0 : cause;
  assign bus.data_bus_read = bus.data_bus_addr == BASE_ADDR + OFF_MASK ? mask :
                             bus.data_bus_addr == BASE_ADDR + OFF_PENDING ? pending :
                             bus.data_bus_addr == BASE_ADDR + OFF_ACTIVE ? active :
                             bus.data_bus_addr == BASE_ADDR + OFF_CTRL ? {13'd0, state, enable} : 16'h0;
  irq_priority_encoder #(.N(NUM_IRQ_MAX)) u_enc (
    .req(eligible),
    .idx(idx),
    .valid(valid)
  );
  // register block; a low request line re-sets its pending bit after any clear in the same cycle
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      mask <= '0;
      pending <= '0;
      enable <= 1'b0;
    end else begin
      if (wr_mask) mask <= bus.data_bus_write & VALID;
      if (wr_ctrl) enable <= bus.data_bus_write[0];
      pending <= (pending & ~w1c & ~ack_clr) | hw_set;
    end
  // request/service FSM; cause is frozen from the IDLE decision until the handler returns
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state <= IDLE;
      cause <= '0;
      active <= '0;
    end else
      case (state)
        IDLE: if (enable && valid) begin
          cause <= idx;
          state <= REQUEST;
        end
        REQUEST: if (cpu_irq_ack) begin
          active <= cause_hot;
          state <= ACTIVE;
        end
        ACTIVE: if (cpu_irq_done) begin
          active <= '0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
endmodule

// File: tb/tb_interrupt_control_unit.sv
// tb_interrupt_control_unit: table-driven scoreboard bench for the interrupt control unit
module tb_interrupt_control_unit;
  localparam logic [7:0] M = 8'h0, P = 8'h4, A = 8'h8, C = 8'hC, U = 8'h10;
  typedef struct {
    logic [7:0] lines;
    logic [1:0] mode;
    logic sel;
    logic [7:0] off;
    logic [15:0] wd;
    logic ack;
    logic done;
    logic irq;
    logic [3:0] cause;
    logic [15:0] rd;
  } vec_t;
  typedef struct {
    logic irq;
    logic [3:0] cause;
    logic [15:0] rd;
  } exp_t;
  logic clk = 1'b0;
  logic reset;
  logic [7:0] irq_lines;
  logic cpu_irq, cpu_irq_ack, cpu_irq_done;
  logic [3:0] cpu_irq_cause;
  vec_t tbl[$];
  exp_t sb[$];
  exp_t e;
  int checks = 0, failures = 0;
  interrupt_control_unit_if bus();
  interrupt_control_unit #(.NUM_IRQ(8), .BASE_ADDR(32'h4000)) dut (
    .clk(clk),
    .reset(reset),
    .irq_lines(irq_lines),
    .cpu_irq(cpu_irq),
    .cpu_irq_cause(cpu_irq_cause),
    .cpu_irq_ack(cpu_irq_ack),
    .cpu_irq_done(cpu_irq_done),
    .bus(bus)
  );
  always #5 clk = ~clk;
  function automatic vec_t mk(logic [7:0] l, logic [1:0] m, logic s, logic [7:0] o, logic [15:0] w,
                              logic a, logic d, logic i, logic [3:0] c, logic [15:0] r);
    mk = '{l, m, s, o, w, a, d, i, c, r};
  endfunction
  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask
  task automatic drive(input vec_t v);
    irq_lines = v.lines;
    bus.data_bus_mode = v.mode;
    bus.data_bus_select = v.sel;
    bus.data_bus_addr = 32'h4000 + 32'(v.off);
    bus.data_bus_write = v.wd;
    cpu_irq_ack = v.ack;
    cpu_irq_done = v.done;
  endtask
  task automatic read_chk(input string name, input logic [7:0] off, input logic [15:0] req);
    bus.data_bus_addr = 32'h4000 + 32'(off);
    #1;
    chk(name, bus.data_bus_read, req);
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end
  initial begin
    drive(mk('hFF, 0, 0, C, 0, 0, 0, 0, 0, 0));
    reset = 1'b0;
    #1;
    chk("reset_irq", 16'(cpu_irq), 0);
    chk("reset_cause", 16'(cpu_irq_cause), 0);
    read_chk("reset_ctrl", C, 0);
    read_chk("reset_mask", M, 0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    tbl.push_back(mk('hFF, 2, 1, M, 'h0004, 0, 0, 0, 0, 'h0004));
    tbl.push_back(mk('hFF, 2, 1, C, 'h0001, 0, 0, 0, 0, 'h0001));
    tbl.push_back(mk('hFB, 0, 0, P, 0, 0, 0, 0, 0, 'h0004));
    tbl.push_back(mk('hFF, 0, 0, C, 0, 0, 0, 1, 2, 'h0003));
    tbl.push_back(mk('hFF, 0, 0, A, 0, 1, 0, 0, 2, 'h0004));
    tbl.push_back(mk('hFF, 0, 0, P, 0, 0, 0, 0, 2, 'h0000));
    tbl.push_back(mk('hFF, 0, 0, A, 0, 0, 1, 0, 0, 'h0000));
    tbl.push_back(mk('hFF, 2, 1, M, 'h00FF, 0, 0, 0, 0, 'h00FF));
    tbl.push_back(mk('hD7, 0, 0, P, 0, 0, 0, 0, 0, 'h0028));
    tbl.push_back(mk('hFF, 0, 0, C, 0, 0, 0, 1, 3, 'h0003));
    tbl.push_back(mk('hFF, 0, 0, P, 0, 1, 0, 0, 3, 'h0020));
    tbl.push_back(mk('hFF, 0, 0, A, 0, 0, 1, 0, 0, 'h0000));
    tbl.push_back(mk('hFF, 0, 0, C, 0, 0, 0, 1, 5, 'h0003));
    tbl.push_back(mk('hFF, 0, 0, A, 0, 1, 0, 0, 5, 'h0020));
    tbl.push_back(mk('hFF, 0, 0, P, 0, 0, 1, 0, 0, 'h0000));
    tbl.push_back(mk('hFF, 2, 1, M, 'h0000, 0, 0, 0, 0, 'h0000));
    tbl.push_back(mk('hFD, 0, 0, P, 0, 0, 0, 0, 0, 'h0002));
    tbl.push_back(mk('hFF, 0, 0, C, 0, 0, 0, 0, 0, 'h0001));
    tbl.push_back(mk('hFF, 2, 1, M, 'h0002, 0, 0, 0, 0, 'h0002));
    tbl.push_back(mk('hFF, 0, 0, C, 0, 0, 0, 1, 1, 'h0003));
    tbl.push_back(mk('hFF, 0, 0, A, 0, 1, 0, 0, 1, 'h0002));
    tbl.push_back(mk('hFF, 0, 0, P, 0, 0, 1, 0, 0, 'h0000));
    tbl.push_back(mk('hFF, 2, 1, M, 'h0010, 0, 0, 0, 0, 'h0010));
    tbl.push_back(mk('hEF, 0, 0, P, 0, 0, 0, 0, 0, 'h0010));
    tbl.push_back(mk('hEF, 0, 0, C, 0, 0, 0, 1, 4, 'h0003));
    tbl.push_back(mk('hEF, 0, 0, P, 0, 1, 0, 0, 4, 'h0010));
    tbl.push_back(mk('hFF, 0, 0, A, 0, 0, 0, 0, 4, 'h0010));
    tbl.push_back(mk('hFF, 2, 1, P, 'h0010, 0, 0, 0, 4, 'h0000));
    tbl.push_back(mk('hFF, 0, 0, A, 0, 1, 0, 0, 4, 'h0010));
    tbl.push_back(mk('hFF, 0, 0, A, 0, 0, 1, 0, 0, 'h0000));
    tbl.push_back(mk('hFF, 0, 0, C, 0, 0, 1, 0, 0, 'h0001));
    tbl.push_back(mk('hFF, 0, 0, C, 0, 1, 0, 0, 0, 'h0001));
    tbl.push_back(mk('hFF, 2, 1, U, 'hFFFF, 0, 0, 0, 0, 'h0000));
    tbl.push_back(mk('hFF, 2, 0, M, 'h00FF, 0, 0, 0, 0, 'h0010));
    tbl.push_back(mk('hFF, 1, 1, M, 'h00FF, 0, 0, 0, 0, 'h0010));
    tbl.push_back(mk('hFF, 2, 1, A, 'hFFFF, 0, 0, 0, 0, 'h0000));
    tbl.push_back(mk('hFF, 2, 1, M, 'hFFFF, 0, 0, 0, 0, 'h00FF));
    tbl.push_back(mk('hBF, 2, 1, P, 'h0040, 0, 0, 0, 0, 'h0040));
    tbl.push_back(mk('hFF, 0, 0, C, 0, 0, 0, 1, 6, 'h0003));
    tbl.push_back(mk('hFF, 2, 1, C, 'h0000, 0, 0, 1, 6, 'h0002));
    tbl.push_back(mk('hFF, 2, 1, M, 'h0000, 0, 0, 1, 6, 'h0000));
    tbl.push_back(mk('hFD, 0, 0, C, 0, 0, 0, 1, 6, 'h0002));
    tbl.push_back(mk('hFF, 0, 0, A, 0, 1, 0, 0, 6, 'h0040));
    foreach (tbl[i]) begin
      @(negedge clk);
      drive(tbl[i]);
      sb.push_back('{tbl[i].irq, tbl[i].cause, tbl[i].rd});
      @(posedge clk);
      #1;
      e = sb.pop_front();
      chk($sformatf("v%0d_irq", i), 16'(cpu_irq), 16'(e.irq));
      chk($sformatf("v%0d_cause", i), 16'(cpu_irq_cause), 16'(e.cause));
      chk($sformatf("v%0d_rdata", i), bus.data_bus_read, e.rd);
    end
    @(negedge clk);
    drive(mk('hFF, 0, 0, P, 0, 0, 0, 0, 0, 0));
    read_chk("pre_reset_pending", P, 'h0002);
    reset = 1'b0;
    #1;
    chk("active_reset_irq", 16'(cpu_irq), 0);
    chk("active_reset_cause", 16'(cpu_irq_cause), 0);
    read_chk("active_reset_mask", M, 0);
    read_chk("active_reset_pending", P, 0);
    read_chk("active_reset_active", A, 0);
    read_chk("active_reset_ctrl", C, 0);
    irq_lines = 8'h00;
    @(posedge clk);
    #1;
    read_chk("held_reset_pending", P, 0);
    chk("held_reset_irq", 16'(cpu_irq), 0);
    @(negedge clk);
    reset = 1'b1;
    irq_lines = 8'hFF;
    cpu_irq_done = 1'b1;
    @(posedge clk);
    #1;
    chk("stray_done_irq", 16'(cpu_irq), 0);
    read_chk("stray_done_ctrl", C, 0);
    read_chk("stray_done_active", A, 0);
    @(negedge clk);
    cpu_irq_done = 1'b0;
    @(posedge clk);
    #1;
    chk("post_reset_irq", 16'(cpu_irq), 0);
    read_chk("post_reset_pending", P, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
